// File: rtl/signed_multiply_by_power_of_2_iterative.sv
// Iterative signed left shift (res = a * 2**shift), one bit per clock, valid/ready on both sides.
// Define SHL_SATURATE_EN to clamp overflowing results; otherwise the result wraps.
module signed_multiply_by_power_of_2_iterative #(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shift,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  res,
  output logic          overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  acc_q;
  logic [SW-1:0] cnt_q;
  logic          ovf_q;
  logic [N-1:0]  res_q;
  logic          overflow_q;

  logic [N-1:0]  acc_shl;
  logic          ovf_nxt;
  logic [N-1:0]  res_fin;

  assign up_ready   = (state_q == IDLE);
  assign down_valid = (state_q == DONE);
  assign res        = res_q;
  assign overflow   = overflow_q;

  // A step overflows when the bit shifted into the sign position differs from the sign.
  assign acc_shl = {acc_q[N-2:0], 1'b0};
  assign ovf_nxt = ovf_q | (acc_q[N-1] ^ acc_q[N-2]);

`ifdef SHL_SATURATE_EN
  logic sgn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q <= 1'b0;
    end else if (state_q == IDLE && up_valid) begin
      sgn_q <= a[N-1];
    end
  end

  assign res_fin = ovf_nxt ? (sgn_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) : acc_shl;
`else
  assign res_fin = acc_shl;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (up_valid) state_d = (shift == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt_q == SW'(1)) state_d = DONE;
      DONE:    if (down_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      res_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && up_valid) begin
        acc_q <= a;
        cnt_q <= shift;
        ovf_q <= 1'b0;
        // Zero shift goes straight to DONE, so publish the operand unchanged now.
        if (shift == '0) begin
          res_q      <= a;
          overflow_q <= 1'b0;
        end
      end else if (state_q == SHIFT) begin
        acc_q <= acc_shl;
        cnt_q <= cnt_q - 1'b1;
        ovf_q <= ovf_nxt;
        if (cnt_q == SW'(1)) begin
          res_q      <= res_fin;
          overflow_q <= ovf_nxt;
        end
      end
    end
  end

endmodule
